// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with per-register busy scoreboard.
// NUM_RD combinational read ports and one write port; x0 reads as zero.
// After reset a clear sequencer zeroes x1..x(DEPTH-1) before the file is usable.
// Optional feature: define RF_BYPASS_EN to forward same-cycle writeback data
// (and a cleared busy flag) to read ports addressing the register being written.
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata,
    output logic [NUM_RD-1:0]            o_rbusy,
    input  logic                         i_issue_en,
    input  logic [ADDR_WIDTH-1:0]        i_issue_rd,
    input  logic                         i_wen,
    input  logic [ADDR_WIDTH-1:0]        i_waddr,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    output logic                         o_ready
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // state | meaning
    // INIT  | clear sequencer zeroing rf[cnt], cnt = 1 .. DEPTH-1; file not usable
    // RUN   | normal operation; left only through rst
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_rf [DEPTH];
    logic [DEPTH-1:0]        r_busy;

    logic                    w_wr_ok;
    logic [DEPTH-1:0]        w_busy_nxt;
    logic [ADDR_WIDTH-1:0]   w_ra;

    // a writeback only lands once the file is usable, and never into x0
    assign w_wr_ok = i_wen & r_ready & (i_waddr != '0);
    assign o_ready = r_ready;

    // sequencer: walk the clear counter, then park in RUN with ready held high
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_INIT;
            r_cnt   <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // storage is not reset; it is cleared by the sequencer or written back in RUN
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT && !i_rst) begin
            r_rf[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_rf[i_waddr] <= i_wdata;
        end
    end

    // next busy vector: writeback clears, issue sets, and set wins on a collision
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wen && (i_waddr != '0)) begin
            w_busy_nxt[i_waddr] = 1'b0;
        end
        if (i_issue_en && (i_issue_rd != '0)) begin
            w_busy_nxt[i_issue_rd] = 1'b1;
        end
    end

    // scoreboard only tracks hazards once the file is in RUN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
        end else if (r_state == ST_RUN) begin
            r_busy <= w_busy_nxt;
        end
    end

    // read ports: zero while in reset/INIT or when addressing x0
    always_comb begin
        o_rdata = '0;
        o_rbusy = '0;
        w_ra    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra = i_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (!i_rst && r_ready && (w_ra != '0)) begin
`ifdef RF_BYPASS_EN
                if (w_wr_ok && (w_ra == i_waddr)) begin
                    o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = i_wdata;
                    o_rbusy[i]                          = 1'b0;
                end else begin
                    o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = r_rf[w_ra];
                    o_rbusy[i]                          = r_busy[w_ra];
                end
`else
                o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = r_rf[w_ra];
                o_rbusy[i]                          = r_busy[w_ra];
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters).
// Expected values are queued when stimulus is applied and compared at the
// following falling edge against the DUT outputs.
module tb_regfile_sb;

    logic        i_clk;
    logic        i_rst;
    logic [9:0]  i_raddr;
    logic [63:0] o_rdata;
    logic [1:0]  o_rbusy;
    logic        i_issue_en;
    logic [4:0]  i_issue_rd;
    logic        i_wen;
    logic [4:0]  i_waddr;
    logic [31:0] i_wdata;
    logic        o_ready;

    regfile_sb dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_raddr    (i_raddr),
        .o_rdata    (o_rdata),
        .o_rbusy    (o_rbusy),
        .i_issue_en (i_issue_en),
        .i_issue_rd (i_issue_rd),
        .i_wen      (i_wen),
        .i_waddr    (i_waddr),
        .i_wdata    (i_wdata),
        .o_ready    (o_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // observed-signal selectors
    localparam int SEL_RD0 = 0, SEL_RD1 = 1, SEL_BZ0 = 2, SEL_BZ1 = 3, SEL_RDY = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        q_exp.push_back(e);
    endtask

    // step past the next rising edge; inputs are changed here
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // drain the scoreboard at the falling edge
    task automatic samp();
        exp_t        e;
        logic [31:0] obs;
        @(negedge i_clk);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            case (e.sel)
                SEL_RD0: obs = o_rdata[31:0];
                SEL_RD1: obs = o_rdata[63:32];
                SEL_BZ0: obs = {31'b0, o_rbusy[0]};
                SEL_BZ1: obs = {31'b0, o_rbusy[1]};
                default: obs = {31'b0, o_ready};
            endcase
            chk(e.tag, obs, e.val);
        end
    endtask

    // 31-edge clear after rst release; port 0 must read zero throughout
    task automatic clear_seq(input string tag);
        for (int k = 1; k <= 31; k++) begin
            cyc();
            if (k == 31) begin
                i_wen      = 1'b0;
                i_issue_en = 1'b0;
            end
            push($sformatf("%s_ready_e%0d", tag, k), SEL_RDY, (k == 31) ? 32'd1 : 32'd0);
            push($sformatf("%s_rd0_e%0d", tag, k), SEL_RD0, 32'd0);
            samp();
        end
    endtask

    initial begin
        i_rst      = 1'b1;
        i_raddr    = '0;
        i_issue_en = 1'b0;
        i_issue_rd = '0;
        i_wen      = 1'b0;
        i_waddr    = '0;
        i_wdata    = '0;

        // reset state
        repeat (2) cyc();
        i_raddr = {5'd2, 5'd3};
        push("rst_ready", SEL_RDY, 32'd0);
        push("rst_rbusy0", SEL_BZ0, 32'd0);
        push("rst_rdata0", SEL_RD0, 32'd0);
        samp();

        // 1: release with a writeback held active; it must be ignored during INIT
        cyc();
        i_rst   = 1'b0;
        i_wen   = 1'b1;
        i_waddr = 5'd3;
        i_wdata = 32'd5;
        clear_seq("init");

        // 2: write x5, read it on both ports the next cycle
        cyc();
        i_wen   = 1'b1;
        i_waddr = 5'd5;
        i_wdata = 32'hDEADBEEF;
        cyc();
        i_wen   = 1'b0;
        i_raddr = {5'd5, 5'd5};
        push("x5_port0", SEL_RD0, 32'hDEADBEEF);
        push("x5_port1", SEL_RD1, 32'hDEADBEEF);
        samp();

        // 3: x0 is immune to writes and issue
        cyc();
        i_wen      = 1'b1;
        i_waddr    = 5'd0;
        i_wdata    = 32'h1234;
        i_issue_en = 1'b1;
        i_issue_rd = 5'd0;
        i_raddr    = {5'd0, 5'd0};
        push("x0_same_rd0", SEL_RD0, 32'd0);
        push("x0_same_rd1", SEL_RD1, 32'd0);
        samp();
        cyc();
        i_wen      = 1'b0;
        i_issue_en = 1'b0;
        push("x0_rd0", SEL_RD0, 32'd0);
        push("x0_busy0", SEL_BZ0, 32'd0);
        push("x0_busy1", SEL_BZ1, 32'd0);
        samp();

        // 4: scoreboard on x7
        cyc();
        i_issue_en = 1'b1;
        i_issue_rd = 5'd7;
        i_raddr    = {5'd8, 5'd7};
        push("x7_busy_pre", SEL_BZ0, 32'd0);
        samp();
        cyc();
        push("x7_busy_set", SEL_BZ0, 32'd1);
        samp();
        cyc();
        i_wen   = 1'b1;
        i_waddr = 5'd7;
        i_wdata = 32'h77;
        push("x8_not_busy", SEL_BZ1, 32'd0);
        samp();
        cyc();
        i_issue_en = 1'b0;
        push("x7_set_wins", SEL_BZ0, BYP ? 32'd0 : 32'd1);
        samp();
        cyc();
        i_wen = 1'b0;
        push("x7_cleared", SEL_BZ0, 32'd0);
        push("x7_data", SEL_RD0, 32'h77);
        samp();

        // 5: same-cycle write and read of x9
        cyc();
        i_wen   = 1'b1;
        i_waddr = 5'd9;
        i_wdata = 32'hA5;
        i_raddr = {5'd5, 5'd9};
        push("x9_same_cycle", SEL_RD0, BYP ? 32'hA5 : 32'd0);
        push("x9_same_busy", SEL_BZ0, 32'd0);
        push("x5_other_port", SEL_RD1, 32'hDEADBEEF);
        samp();
        cyc();
        i_wen = 1'b0;
        push("x9_next_cycle", SEL_RD0, 32'hA5);
        samp();

        // bypass of the busy flag on a pending register
        cyc();
        i_issue_en = 1'b1;
        i_issue_rd = 5'd10;
        i_raddr    = {5'd0, 5'd10};
        cyc();
        i_issue_en = 1'b0;
        i_wen      = 1'b1;
        i_waddr    = 5'd10;
        i_wdata    = 32'hC0FFEE;
        push("x10_busy_wb", SEL_BZ0, BYP ? 32'd0 : 32'd1);
        push("x10_data_wb", SEL_RD0, BYP ? 32'hC0FFEE : 32'd0);
        samp();
        cyc();
        i_wen = 1'b0;

        // 6: reset in RUN with x4 busy, then again mid-INIT
        i_wen   = 1'b1;
        i_waddr = 5'd4;
        i_wdata = 32'h44;
        cyc();
        i_wen      = 1'b0;
        i_issue_en = 1'b1;
        i_issue_rd = 5'd4;
        cyc();
        i_issue_en = 1'b0;
        i_raddr    = {5'd5, 5'd4};
        push("x4_before_rst", SEL_RD0, 32'h44);
        push("x4_busy_before", SEL_BZ0, 32'd1);
        samp();
        cyc();
        i_rst = 1'b1;
        push("run_rst_ready", SEL_RDY, 32'd0);
        push("run_rst_busy0", SEL_BZ0, 32'd0);
        push("run_rst_rd0", SEL_RD0, 32'd0);
        samp();
        cyc();
        i_rst = 1'b0;
        for (int k = 0; k < 9; k++) cyc();
        i_rst = 1'b1;
        push("init_rst_ready", SEL_RDY, 32'd0);
        samp();
        cyc();
        i_rst = 1'b0;
        clear_seq("reclr");
        push("x4_after_clear", SEL_RD0, 32'd0);
        push("x4_busy_after", SEL_BZ0, 32'd0);
        push("x5_after_clear", SEL_RD1, 32'd0);
        samp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
